// File: rtl/simple_mcu_pkg.sv
// Shared constants and types for the simple_mcu teaching core: opcodes, FSM states,
// bus-select encoding and the default program image.
package simple_mcu_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 8;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef logic [2:0] state_t;
    localparam state_t StIdle = 3'd0;
    localparam state_t StT0   = 3'd1;
    localparam state_t StT1   = 3'd2;
    localparam state_t StT2   = 3'd3;
    localparam state_t StT3   = 3'd4;

    typedef enum logic [1:0] {
        BusZero,
        BusDin,
        BusReg,
        BusG
    } bus_sel_e;

    // Word 0 sits in the least-significant slice.
    localparam logic [DEF_DATA_W*(2**DEF_ADDR_W)-1:0] ROM_DEFAULT = {
        16'h01C0,                                  // 15: halt
        {8{16'h0100}},                             // 7..14: nop
        16'h0010,                                  // 6: mv R2,R0
        16'h00C1,                                  // 5: sub R0,R1
        16'h0081,                                  // 4: add R0,R1
        16'h0003, 16'h0048,                        // 2,3: mvi R1,#3
        16'h0005, 16'h0040                         // 0,1: mvi R0,#5
    };

endpackage

// File: rtl/simple_mcu_rom.sv
// Combinational instruction ROM; contents fixed at elaboration from a packed image.
module simple_mcu_rom
    import simple_mcu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] IMAGE = ROM_DEFAULT
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_word
        assign mem[i] = IMAGE[i*DATA_W +: DATA_W];
    end

    assign data = mem[addr];

endmodule

// File: rtl/simple_mcu.sv
// Minimal 16-bit microcontroller: multi-cycle FSM, eight registers, accumulator A,
// result register G and one shared bus, fed by an internal instruction ROM.
module simple_mcu
    import simple_mcu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] ROM_IMAGE = ROM_DEFAULT
) (
    input  logic              Pclk,
    input  logic              Resetn,
    input  logic              Run,
    output logic              Done,
    output logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] counter
);

    logic [DATA_W-1:0] din;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] counter_q, counter_d;
    logic [8:0]        ir_q;
    logic              ir_we;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] a_q, g_q, alu_res;
    logic              reg_we, a_we, g_we;
    bus_sel_e          bus_sel;
    logic [2:0]        bus_reg;
    logic [2:0]        din_op, ir_op, ir_x, ir_y;

    simple_mcu_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IMAGE  (ROM_IMAGE)
    ) u_rom (
        .addr (counter_q),
        .data (din)
    );

    assign din_op  = din[8:6];
    assign ir_op   = ir_q[8:6];
    assign ir_x    = ir_q[5:3];
    assign ir_y    = ir_q[2:0];
    assign counter = counter_q;

    // Fetch decodes straight from DIN because IR only loads at the end of T0.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        a_we      = 1'b0;
        g_we      = 1'b0;
        bus_sel   = BusZero;
        bus_reg   = '0;
        Done      = 1'b0;
        case (state_q)
            StIdle: begin
                if (Run) begin
                    state_d = StT0;
                end
            end
            StT0: begin
                bus_sel   = BusDin;
                ir_we     = 1'b1;
                counter_d = counter_q + ADDR_W'(1);
                case (din_op)
                    OP_MV, OP_MVI, OP_ADD, OP_SUB: state_d = StT1;
                    OP_HALT: begin
                        Done    = 1'b1;
                        state_d = StIdle;
                    end
                    default: begin
                        Done    = 1'b1;
                        state_d = StT0;
                    end
                endcase
            end
            StT1: begin
                case (ir_op)
                    OP_MV: begin
                        bus_sel = BusReg;
                        bus_reg = ir_y;
                        reg_we  = 1'b1;
                        Done    = 1'b1;
                        state_d = StT0;
                    end
                    OP_MVI: begin
                        bus_sel   = BusDin;
                        reg_we    = 1'b1;
                        counter_d = counter_q + ADDR_W'(1);
                        Done      = 1'b1;
                        state_d   = StT0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = BusReg;
                        bus_reg = ir_x;
                        a_we    = 1'b1;
                        state_d = StT2;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StT2: begin
                bus_sel = BusReg;
                bus_reg = ir_y;
                g_we    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                bus_sel = BusG;
                reg_we  = 1'b1;
                Done    = 1'b1;
                state_d = StT0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (bus_sel)
            BusDin:  bus = din;
            BusReg:  bus = regs_q[bus_reg];
            BusG:    bus = g_q;
            default: bus = '0;
        endcase
    end

    assign alu_res = (ir_op == OP_SUB) ? a_q - bus : a_q + bus;

    always_ff @(posedge Pclk or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= StIdle;
            counter_q <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            g_q       <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            if (ir_we) ir_q <= din[8:0];
            if (a_we)  a_q  <= bus;
            if (g_we)  g_q  <= alu_res;
        end
    end

    // Destination is always Rx; all writes take the bus value of the current cycle.
    always_ff @(posedge Pclk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[ir_x] <= bus;
        end
    end

endmodule

// File: tb/tb_simple_mcu.sv
// Bench for simple_mcu: two instances (default program and an alternate program) checked
// every cycle against an instruction-level model, plus literal checkpoints.
module tb_simple_mcu;

    localparam logic [255:0] IMG1 = {
        16'h0050, 16'h0100, 16'h0006, 16'h0140, 16'h00B7, 16'h00FD, 16'h1234, 16'h0078,
        16'hFF80, 16'h00AD, 16'h002B, 16'h00DC, 16'h0001, 16'h0060, 16'h01C0, 16'h0070
    };

    logic        Pclk = 1'b0;
    logic        Resetn;
    logic        Run;
    logic        done0, done1;
    logic [15:0] bus0, bus1;
    logic [3:0]  cnt0, cnt1;

    simple_mcu dut0 (
        .Pclk    (Pclk),
        .Resetn  (Resetn),
        .Run     (Run),
        .Done    (done0),
        .bus     (bus0),
        .counter (cnt0)
    );

    simple_mcu #(
        .ROM_IMAGE (IMG1)
    ) dut1 (
        .Pclk    (Pclk),
        .Resetn  (Resetn),
        .Run     (Run),
        .Done    (done1),
        .bus     (bus1),
        .counter (cnt1)
    );

    always #5 Pclk = ~Pclk;

    typedef struct packed {
        logic [15:0] bus;
        logic [3:0]  cnt;
        logic        done;
    } exp_t;

    exp_t        expq [2][$];
    logic [15:0] rom_img [2][16];
    logic [15:0] mreg [2][8];
    logic [3:0]  mpc [2];
    bit          mrun [2];
    int          errors = 0;
    int          checks = 0;

    logic [15:0] lb0 [40];
    logic [15:0] lb1 [40];
    logic [3:0]  lc0 [40];
    logic        ld0 [40];
    logic        ld1 [40];

    function automatic exp_t mk(input logic [15:0] b, input logic [3:0] c, input logic d);
        exp_t e;
        e.bus  = b;
        e.cnt  = c;
        e.done = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset(input int id);
        for (int r = 0; r < 8; r++) mreg[id][r] = '0;
        mpc[id]  = '0;
        mrun[id] = 1'b0;
        expq[id].delete();
    endtask

    // Execute one whole instruction architecturally and queue its per-cycle outputs.
    task automatic expand(input int id);
        logic [15:0] w, imm, res;
        logic [2:0]  op, x, y;
        logic [3:0]  pc, p1, p2;
        w  = rom_img[id][mpc[id]];
        op = w[8:6];
        x  = w[5:3];
        y  = w[2:0];
        pc = mpc[id];
        p1 = pc + 4'd1;
        p2 = p1 + 4'd1;
        case (op)
            3'd0: begin
                expq[id].push_back(mk(w, pc, 1'b0));
                expq[id].push_back(mk(mreg[id][y], p1, 1'b1));
                mreg[id][x] = mreg[id][y];
                mpc[id] = p1;
            end
            3'd1: begin
                imm = rom_img[id][p1];
                expq[id].push_back(mk(w, pc, 1'b0));
                expq[id].push_back(mk(imm, p1, 1'b1));
                mreg[id][x] = imm;
                mpc[id] = p2;
            end
            3'd2, 3'd3: begin
                res = (op == 3'd2) ? mreg[id][x] + mreg[id][y] : mreg[id][x] - mreg[id][y];
                expq[id].push_back(mk(w, pc, 1'b0));
                expq[id].push_back(mk(mreg[id][x], p1, 1'b0));
                expq[id].push_back(mk(mreg[id][y], p1, 1'b0));
                expq[id].push_back(mk(res, p1, 1'b1));
                mreg[id][x] = res;
                mpc[id] = p1;
            end
            3'd7: begin
                expq[id].push_back(mk(w, pc, 1'b1));
                mrun[id] = 1'b0;
                mpc[id] = p1;
            end
            default: begin
                expq[id].push_back(mk(w, pc, 1'b1));
                mpc[id] = p1;
            end
        endcase
    endtask

    // Advance the model across the coming rising edge given the inputs driven for it.
    task automatic step(input int id, input logic run_v, input logic rstn_v);
        bit was_idle;
        if (!rstn_v) begin
            model_reset(id);
        end else begin
            was_idle = (expq[id].size() == 0);
            if (!was_idle) void'(expq[id].pop_front());
            if (expq[id].size() == 0) begin
                if (mrun[id]) begin
                    expand(id);
                end else if (was_idle && run_v) begin
                    mrun[id] = 1'b1;
                    expand(id);
                end
            end
        end
    endtask

    task automatic compare_all();
        exp_t        e;
        logic [15:0] ab;
        logic [3:0]  ac;
        logic        ad;
        for (int id = 0; id < 2; id++) begin
            e  = (expq[id].size() != 0) ? expq[id][0] : mk(16'h0, mpc[id], 1'b0);
            ab = (id == 0) ? bus0 : bus1;
            ac = (id == 0) ? cnt0 : cnt1;
            ad = (id == 0) ? done0 : done1;
            check($sformatf("dut%0d bus", id), 32'(ab), 32'(e.bus));
            check($sformatf("dut%0d counter", id), 32'(ac), 32'(e.cnt));
            check($sformatf("dut%0d Done", id), 32'(ad), 32'(e.done));
        end
    endtask

    task automatic tick(input logic run_v, input logic rstn_v);
        compare_all();
        Run    = run_v;
        Resetn = rstn_v;
        step(0, run_v, rstn_v);
        step(1, run_v, rstn_v);
        @(negedge Pclk);
    endtask

    initial begin
        rom_img[0][0] = 16'h0040;
        rom_img[0][1] = 16'h0005;
        rom_img[0][2] = 16'h0048;
        rom_img[0][3] = 16'h0003;
        rom_img[0][4] = 16'h0081;
        rom_img[0][5] = 16'h00C1;
        rom_img[0][6] = 16'h0010;
        for (int i = 7; i < 15; i++) rom_img[0][i] = 16'h0100;
        rom_img[0][15] = 16'h01C0;
        for (int i = 0; i < 16; i++) rom_img[1][i] = IMG1[i*16 +: 16];

        Resetn = 1'b0;
        Run    = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge Pclk);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        check("idle dut0 bus", 32'(bus0), 32'h0);
        check("idle dut0 counter", 32'(cnt0), 32'h0);

        // First run; a Run pulse during T1 of the first mvi must be ignored.
        tick(1'b1, 1'b1);
        for (int i = 1; i < 35; i++) begin
            lb0[i] = bus0;
            lc0[i] = cnt0;
            ld0[i] = done0;
            lb1[i] = bus1;
            ld1[i] = done1;
            tick(i == 2, 1'b1);
        end
        check("c1 fetch mvi R0", 32'(lb0[1]), 32'h0040);
        check("c2 R0 imm", 32'(lb0[2]), 32'h0005);
        check("c2 Done", 32'(ld0[2]), 32'h1);
        check("c3 counter", 32'(lc0[3]), 32'h2);
        check("c4 R1 imm", 32'(lb0[4]), 32'h0003);
        check("c8 add result", 32'(lb0[8]), 32'h0008);
        check("c8 Done", 32'(ld0[8]), 32'h1);
        check("c12 sub result", 32'(lb0[12]), 32'h0005);
        check("c14 mv R2 value", 32'(lb0[14]), 32'h0005);
        check("c23 halt bus", 32'(lb0[23]), 32'h01C0);
        check("c23 halt counter", 32'(lc0[23]), 32'hF);
        check("c23 halt Done", 32'(ld0[23]), 32'h1);
        check("c24 idle counter", 32'(lc0[24]), 32'h0);
        check("c24 idle Done", 32'(ld0[24]), 32'h0);
        check("alt c5 fetch sub", 32'(lb1[5]), 32'h00DC);
        check("alt c7 no Done", 32'(ld1[7]), 32'h0);
        check("alt c8 sub wrap", 32'(lb1[8]), 32'hFFFF);
        check("alt c8 Done", 32'(ld1[8]), 32'h1);
        check("alt c14 add wrap", 32'(lb1[14]), 32'hFFFE);

        // Second run restarts at 0; reset lands in T2 of the add.
        tick(1'b1, 1'b1);
        check("rerun counter", 32'(cnt0), 32'h0);
        check("rerun fetch", 32'(bus0), 32'h0040);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        check("T2 add bus", 32'(bus0), 32'h0003);
        tick(1'b0, 1'b0);
        check("mid-reset bus", 32'(bus0), 32'h0);
        check("mid-reset counter", 32'(cnt0), 32'h0);
        check("mid-reset Done", 32'(done0), 32'h0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 199) != 0);
        end
        tick(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simple_mcu.md
Name: simple_mcu

Overview:
- Minimal 16-bit microcontroller: 4-bit program counter addressing an internal 16x16 instruction ROM, eight 16-bit registers R0..R7, accumulator A, result register G, and a shared 16-bit bus.
- Started by a one-cycle Run pulse; then fetches and executes sequentially until a HALT instruction.
- The bus and program counter are exported for observation.
- Top-level compute block of the teaching SoC.

Parameters:
- DATA_W, 16, width of registers, bus and ROM words.
- ADDR_W, 4, program counter and ROM address width (16 words).

Ports:
- Pclk  in  1  single system clock; all state updates on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request, sampled only in IDLE.
- Done  out  1  one-cycle pulse in the final cycle of every instruction.
- bus  out  16  current value driven onto the internal bus.
- counter  out  4  program counter, the current ROM address.

Behaviour:
- Clocking and reset:
  - One clock (Pclk), asynchronous active-low reset (Resetn). Nothing else is clocked.
  - Reset forces state IDLE, counter=0, R0..R7=0, A=0, G=0, IR=0, Done=0, bus=0.
  - Reset mid-instruction aborts the instruction with no partial register write.
- ROM:
  - Combinational read; DIN = ROM[counter].
  - Instruction word: [8:6] opcode, [5:3] X, [2:0] Y; bits [15:9] ignored.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#imm (imm is the next ROM word)
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 111 halt
  - 100..110 nop
- FSM states: IDLE, T0, T1, T2, T3.
- IDLE: Run=1 -> T0; otherwise stay.
- T0 (fetch): IR<=DIN; counter<=counter+1; bus=DIN.
  - mv/mvi/add/sub -> T1.
  - nop: Done=1 -> T0.
  - halt: Done=1 -> IDLE.
- T1:
  - mv: bus=Ry; Rx<=bus; Done=1 -> T0.
  - mvi: bus=DIN; Rx<=bus; counter<=counter+1; Done=1 -> T0.
  - add/sub: bus=Rx; A<=bus -> T2.
- T2: bus=Ry; G<=A+bus (add) or A-bus (sub), modulo 2^16, no flags -> T3.
- T3: bus=G; Rx<=bus; Done=1 -> T0.
- Bus mux: selects DIN, R0..R7 or G; drives 0 in IDLE.
- Latencies from fetch to Done: mv 2 cycles, mvi 2, add/sub 4, nop/halt 1.
- counter wraps 15->0; execution continues across the wrap.
- Run while not in IDLE is ignored.
- Default ROM image (address: word):
  - 0: mvi R0
  - 1: 0x0005
  - 2: mvi R1
  - 3: 0x0003
  - 4: add R0,R1
  - 5: sub R0,R1
  - 6: mv R2,R0
  - 7-14: nop (0x0100)
  - 15: halt (0x01C0)

Decomposition:
- Package simple_mcu_pkg holds: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT), FSM state enum, bus-select enum, DATA_W/ADDR_W defaults.
- One sub-module, simple_mcu_rom: combinational 16x16 ROM holding the default image.
- Datapath and FSM stay in the top level.

Test Plan:
- Reset held 20 ns, Run low -> state IDLE, counter=0, bus=0, Done=0, all registers 0 indefinitely.
- Run pulsed one cycle -> next cycle T0 with bus=ROM[0]=mvi R0; two cycles later Done=1, R0=5, counter=2.
- Continue default program -> R1=3; after the add, bus=8 in T3 and R0=8; after the sub, R0=5; after the mv, R2=5.
- Run to completion -> counter reaches 15, halt fetched, Done pulses once, counter=0, FSM returns to IDLE; a second Run pulse re-executes the program from address 0.
- ROM with sub R3,R4, R3=0, R4=1 -> R3=0xFFFF (wrap-around); Done asserted exactly 4 cycles after fetch.
- Resetn asserted during T2 of an add -> immediate reset values, Rx unchanged; Run ignored while executing (pulse in T1 has no effect).
